aes_block_packer: RTL and testbench

Upstream neighbour of the AES engine. Collects 32-bit words from the HWPE streamer into 128-bit AES blocks and presents them on a 128-bit stream that feeds the engine's `a_i` input. It has a 3-word assembly buffer plus a 1-block output register, so ingestion continues while a finished block waits for the engine. A block counter stops the packer after a programmed number of blocks.

---
 rtl/aes_block_packer_pkg.sv | 30 +++
 rtl/hwpe_stream_intf_stream.sv | 16 +
 rtl/aes_block_packer.sv | 164 ++++++++++++++++
 tb/tb_aes_block_packer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_block_packer_pkg.sv
// aes_package: shared types and constants for the AES input block packer.
// Exports: packer_ctrl_t (start/swap/len), packer_flags_t (busy/done/counters),
//          packer_state_e, and the AES block/word geometry constants.
package aes_package;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_WORD_W  = 32;
  localparam int PACK_WORDS  = AES_BLOCK_W / AES_WORD_W;
  localparam int PACK_LEN_W  = 16;

  typedef struct packed {
    logic                  start;  // one-cycle job start pulse
    logic                  swap;   // byte-reverse every incoming word
    logic [PACK_LEN_W-1:0] len;    // blocks per job, 0 = unlimited
  } packer_ctrl_t;

  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic [1:0]            word_cnt;
    logic [PACK_LEN_W-1:0] blk_cnt;
  } packer_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } packer_state_e;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// hwpe_stream_intf_stream: valid/ready stream bundle with byte strobes.
// Signals: valid, ready, data[DATA_WIDTH-1:0], strb[DATA_WIDTH/8-1:0].
// Modports: source drives valid/data/strb, sink drives ready.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/aes_block_packer.sv
// aes_block_packer: packs 32-bit streamer words into 128-bit AES blocks.
// Ports: clk_i, rst_i (async, active-high), clear_i (sync), enable_i (freeze),
//        in_i word sink, out_o block source, ctrl_i job control, flags_o status.
// Latency: block valid the cycle after its last word; 1 word/cycle sustained.
module aes_block_packer
  import aes_package::*;
#(
  parameter int unsigned IN_WIDTH  = AES_WORD_W,
  parameter int unsigned OUT_WIDTH = AES_BLOCK_W
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic                        enable_i,
  hwpe_stream_intf_stream.sink        in_i,
  hwpe_stream_intf_stream.source      out_o,
  input  packer_ctrl_t                ctrl_i,
  output packer_flags_t               flags_o
);

  localparam int unsigned WORDS     = OUT_WIDTH / IN_WIDTH;
  localparam logic [1:0]  LAST_WORD = 2'(WORDS - 1);

  packer_state_e         r_state;
  packer_state_e         w_state_nxt;
  logic                  w_start_job;

  logic [1:0]            r_word_cnt;
  logic [PACK_LEN_W-1:0] r_blk_cnt;
  logic [PACK_LEN_W-1:0] w_blk_cnt_inc;

  logic [IN_WIDTH-1:0]   r_buf [WORDS-1];
  logic [OUT_WIDTH-1:0]  r_out_dat;
  logic                  r_out_vld;

  logic [IN_WIDTH-1:0]   w_word;
  logic [OUT_WIDTH-1:0]  w_blk;
  logic                  w_last_word;
  logic                  w_in_rdy;
  logic                  w_in_hs;
  logic                  w_out_vld;
  logic                  w_out_hs;
  logic                  w_unused_strb;

  // Input strobes carry no information for whole-word packing.
  assign w_unused_strb = ^in_i.strb;

  assign w_out_vld     = enable_i & r_out_vld;
  assign w_out_hs      = w_out_vld & out_o.ready;
  assign w_last_word   = (r_word_cnt == LAST_WORD);
  assign w_blk_cnt_inc = r_blk_cnt + PACK_LEN_W'(1);

  // The final word of a block needs a free output slot; a slot that drains
  // on this same edge counts as free, which keeps the pipe bubble-free.
  assign w_in_rdy = enable_i && (r_state == ST_RUN) &&
                    (!w_last_word || !r_out_vld || w_out_hs);
  assign w_in_hs  = w_in_rdy & in_i.valid;

  // Optional byte reversal of the incoming word.
  always_comb begin
    w_word = in_i.data;
    if (ctrl_i.swap) begin
      for (int b = 0; b < int'(IN_WIDTH / 8); b++) begin
        w_word[8*b +: 8] = in_i.data[int'(IN_WIDTH) - 8 - 8*b +: 8];
      end
    end
  end

  // Completed block: buffered words in the low slots, current word on top.
  always_comb begin
    w_blk = '0;
    for (int k = 0; k < int'(WORDS) - 1; k++) begin
      w_blk[k*int'(IN_WIDTH) +: IN_WIDTH] = r_buf[k];
    end
    w_blk[(int'(WORDS) - 1)*int'(IN_WIDTH) +: IN_WIDTH] = w_word;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else if (clear_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_job = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (enable_i && ctrl_i.start) begin
          w_state_nxt = ST_RUN;
          w_start_job = 1'b1;
        end
      end
      ST_RUN: begin
        // Job ends when the block bringing the count up to len leaves.
        if (w_out_hs && (ctrl_i.len != '0) && (w_blk_cnt_inc == ctrl_i.len)) begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_word_cnt <= '0;
      r_blk_cnt  <= '0;
      r_out_vld  <= 1'b0;
      r_out_dat  <= '0;
      for (int k = 0; k < int'(WORDS) - 1; k++) begin
        r_buf[k] <= '0;
      end
    end else if (clear_i) begin
      r_word_cnt <= '0;
      r_blk_cnt  <= '0;
      r_out_vld  <= 1'b0;
      r_out_dat  <= '0;
      for (int k = 0; k < int'(WORDS) - 1; k++) begin
        r_buf[k] <= '0;
      end
    end else if (w_start_job) begin
      r_word_cnt <= '0;
      r_blk_cnt  <= '0;
      r_out_vld  <= 1'b0;
    end else begin
      if (w_in_hs) begin
        r_word_cnt <= r_word_cnt + 2'd1;
        if (!w_last_word) begin
          r_buf[r_word_cnt] <= w_word;
        end
      end

      // A load on the draining edge keeps valid high with the new block.
      if (w_in_hs && w_last_word) begin
        r_out_dat <= w_blk;
        r_out_vld <= 1'b1;
      end else if (w_out_hs) begin
        r_out_vld <= 1'b0;
      end

      // Unlimited jobs saturate rather than wrap the block count.
      if (w_out_hs && !((ctrl_i.len == '0) && (&r_blk_cnt))) begin
        r_blk_cnt <= w_blk_cnt_inc;
      end
    end
  end

  assign in_i.ready  = w_in_rdy;
  assign out_o.valid = w_out_vld;
  assign out_o.data  = r_out_dat;
  assign out_o.strb  = '1;

  assign flags_o.busy     = (r_state == ST_RUN) | r_out_vld;
  assign flags_o.done     = (r_state == ST_DONE) & ~r_out_vld;
  assign flags_o.word_cnt = r_word_cnt;
  assign flags_o.blk_cnt  = r_blk_cnt;

endmodule

// File: tb/tb_aes_block_packer.sv
// tb_aes_block_packer: scenario tasks for aes_block_packer with a word-list
// reference model; expected blocks are built from the words the bench sent.
module tb_aes_block_packer;
  import aes_package::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          enable;
  packer_ctrl_t  ctrl;
  packer_flags_t flags;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32))  in_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(128)) out_if ();

  aes_block_packer #(.IN_WIDTH(32), .OUT_WIDTH(128)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .clear_i  (clear),
    .enable_i (enable),
    .in_i     (in_if),
    .out_o    (out_if),
    .ctrl_i   (ctrl),
    .flags_o  (flags)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [127:0] obs_q[$];
  int           obs_t[$];
  int           in_t[$];
  logic [31:0]  words [64];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (out_if.valid && out_if.ready) begin
      obs_q.push_back(out_if.data);
      obs_t.push_back(cyc);
    end
    if (in_if.valid && in_if.ready) in_t.push_back(cyc);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] bsw(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Word k of a block lives at bits [32k+31:32k].
  function automatic logic [127:0] model_blk(input int base, input bit sw);
    logic [127:0] b;
    b = '0;
    for (int k = 0; k < 4; k++) b[32*k +: 32] = sw ? bsw(words[base+k]) : words[base+k];
    return b;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_logs();
    obs_q.delete(); obs_t.delete(); in_t.delete();
  endtask

  task automatic start_job(input logic [15:0] len, input bit sw);
    ctrl.len = len; ctrl.swap = sw; ctrl.start = 1'b1;
    tick(1);
    ctrl.start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int budget, output bit ok);
    ok = 1'b0;
    in_if.valid = 1'b1;
    in_if.data  = w;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (in_if.ready) begin ok = 1'b1; break; end
    end
    tick(1);
    in_if.valid = 1'b0;
  endtask

  task automatic send_n(input int base, input int n, output bit ok);
    bit o;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      send_word(words[base+i], 50, o);
      if (!o) ok = 1'b0;
    end
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (obs_q.size() >= n) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; enable = 1'b1; ctrl = '0;
    in_if.valid = 1'b0; in_if.data = '0; in_if.strb = '1; out_if.ready = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    checks++; if (in_if.ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_if.ready); end
    checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_if.valid); end
    checks++; if (out_if.data !== 128'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_if.data); end
    checks++; if (flags !== '0) begin errors++; $display("FAIL reset_flags: got %h want 0", flags); end
  endtask

  task automatic test_single(input bit sw, input logic [127:0] exp);
    bit ok;
    clr_logs();
    words[0] = 32'h00112233; words[1] = 32'h44556677;
    words[2] = 32'h8899AABB; words[3] = 32'hCCDDEEFF;
    start_job(16'd1, sw);
    send_n(0, 4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_accept sw=%0d: words not all accepted", sw); end
    wait_obs(1, 20, ok);
    tick(2);
    checks++; if (!ok || obs_q.size() != 1) begin errors++; $display("FAIL single_count sw=%0d: got %0d blocks want 1", sw, obs_q.size()); end
    else begin
      checks++; if (obs_q[0] !== exp) begin errors++; $display("FAIL single_data sw=%0d: got %h want %h", sw, obs_q[0], exp); end
      checks++; if (obs_t[0] != in_t[3] + 1) begin errors++; $display("FAIL single_latency sw=%0d: got %0d want %0d", sw, obs_t[0] - in_t[3], 1); end
    end
    in_if.valid = 1'b1;
    tick(1);
    checks++; if (flags.done !== 1'b1 || flags.busy !== 1'b0) begin errors++; $display("FAIL single_done sw=%0d: done=%b busy=%b want 1/0", sw, flags.done, flags.busy); end
    checks++; if (flags.blk_cnt !== 16'd1) begin errors++; $display("FAIL single_blk_cnt sw=%0d: got %0d want 1", sw, flags.blk_cnt); end
    checks++; if (in_if.ready !== 1'b0) begin errors++; $display("FAIL single_in_ready sw=%0d: got %b want 0", sw, in_if.ready); end
    in_if.valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit sw;
    clr_logs();
    sw = 1'($urandom_range(0, 1));
    for (int i = 0; i < 13; i++) words[i] = $urandom;
    start_job(16'd3, sw);
    send_n(0, 12, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_accept: 12 words not accepted"); end
    wait_obs(3, 20, ok);
    for (int c = 0; c < 20; c++) begin
      if (flags.done) break;
      tick(1);
    end
    checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", obs_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (obs_q[i] !== model_blk(4*i, sw)) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", i, obs_q[i], model_blk(4*i, sw)); end
      end
      for (int i = 1; i < 3; i++) begin
        checks++; if (obs_t[i] - obs_t[i-1] != 4) begin errors++; $display("FAIL b2b_spacing%0d: got %0d want 4", i, obs_t[i] - obs_t[i-1]); end
      end
    end
    checks++; if (flags.done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", flags.done); end
    send_word(words[12], 10, ok);
    checks++; if (ok) begin errors++; $display("FAIL b2b_word13: got accepted want stalled"); end
    checks++; if (flags.word_cnt !== 2'd0 || obs_q.size() != 3) begin errors++; $display("FAIL b2b_after: word_cnt=%0d blocks=%0d want 0/3", flags.word_cnt, obs_q.size()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit bad;
    clr_logs();
    for (int i = 0; i < 8; i++) words[i] = $urandom;
    out_if.ready = 1'b0;
    start_job(16'd2, 1'b0);
    send_n(0, 7, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_accept: words 0-6 not accepted"); end
    in_if.valid = 1'b1; in_if.data = words[7];
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (in_if.ready !== 1'b0 || out_if.valid !== 1'b1 || out_if.data !== model_blk(0, 1'b0) || flags.word_cnt !== 2'd3) bad = 1'b1;
    end
    tick(1);
    checks++; if (bad) begin errors++; $display("FAIL bp_stall: in_ready=%b out_valid=%b data=%h want 0/1/%h", in_if.ready, out_if.valid, out_if.data, model_blk(0, 1'b0)); end
    out_if.ready = 1'b1;
    @(negedge clk);
    checks++; if (in_if.ready !== 1'b1 || out_if.valid !== 1'b1) begin errors++; $display("FAIL bp_release: in_ready=%b out_valid=%b want 1/1", in_if.ready, out_if.valid); end
    tick(1);
    in_if.valid = 1'b0;
    wait_obs(2, 20, ok);
    tick(2);
    checks++; if (obs_q.size() != 2 || in_t.size() != 8) begin errors++; $display("FAIL bp_count: blocks=%0d words=%0d want 2/8", obs_q.size(), in_t.size()); end
    else begin
      checks++; if (obs_q[0] !== model_blk(0, 1'b0)) begin errors++; $display("FAIL bp_data0: got %h want %h", obs_q[0], model_blk(0, 1'b0)); end
      checks++; if (obs_q[1] !== model_blk(4, 1'b0)) begin errors++; $display("FAIL bp_data1: got %h want %h", obs_q[1], model_blk(4, 1'b0)); end
      checks++; if (in_t[7] != obs_t[0]) begin errors++; $display("FAIL bp_same_edge: word7 at %0d block1 at %0d want equal", in_t[7], obs_t[0]); end
    end
    checks++; if (flags.done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b want 1", flags.done); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clr_logs();
    for (int i = 0; i < 6; i++) words[i] = $urandom;
    start_job(16'd1, 1'b0);
    send_n(0, 2, ok);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    checks++; if (flags.word_cnt !== 2'd0 || flags.busy !== 1'b0 || flags.done !== 1'b0) begin errors++; $display("FAIL rstmid_flags: word_cnt=%0d busy=%b done=%b want 0/0/0", flags.word_cnt, flags.busy, flags.done); end
    start_job(16'd1, 1'b0);
    send_n(2, 4, ok);
    wait_obs(1, 20, ok);
    tick(2);
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL rstmid_count: got %0d want 1", obs_q.size()); end
    else begin
      checks++; if (obs_q[0] !== model_blk(2, 1'b0)) begin errors++; $display("FAIL rstmid_data: got %h want %h", obs_q[0], model_blk(2, 1'b0)); end
    end
  endtask

  task automatic test_enable();
    bit ok;
    bit bad;
    clr_logs();
    for (int i = 0; i < 4; i++) words[i] = $urandom;
    start_job(16'd1, 1'b1);
    send_n(0, 2, ok);
    enable = 1'b0;
    in_if.valid = 1'b1; in_if.data = words[2];
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (in_if.ready !== 1'b0 || flags.word_cnt !== 2'd2) bad = 1'b1;
    end
    tick(1);
    checks++; if (bad) begin errors++; $display("FAIL en_freeze: in_ready=%b word_cnt=%0d want 0/2", in_if.ready, flags.word_cnt); end
    checks++; if (in_t.size() != 2) begin errors++; $display("FAIL en_handshakes: got %0d want 2", in_t.size()); end
    enable = 1'b1;
    send_n(2, 2, ok);
    wait_obs(1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL en_count: got %0d want 1", obs_q.size()); end
    else begin
      checks++; if (obs_q[0] !== model_blk(0, 1'b1)) begin errors++; $display("FAIL en_data: got %h want %h", obs_q[0], model_blk(0, 1'b1)); end
    end
  endtask

  task automatic test_random();
    bit ok;
    bit sent;
    bit sw;
    bit all_ok;
    clr_logs();
    sw = 1'($urandom_range(0, 1));
    for (int i = 0; i < 24; i++) words[i] = $urandom;
    start_job(16'd0, sw);
    sent = 1'b0;
    all_ok = 1'b1;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          tick($urandom_range(0, 2));
          send_word(words[i], 50, ok);
          if (!ok) all_ok = 1'b0;
        end
        sent = 1'b1;
      end
      begin
        while (!sent) begin
          out_if.ready = 1'($urandom_range(0, 1));
          tick(1);
        end
        out_if.ready = 1'b1;
      end
    join
    wait_obs(6, 50, ok);
    tick(2);
    checks++; if (!all_ok) begin errors++; $display("FAIL rand_accept: not all words accepted"); end
    checks++; if (obs_q.size() != 6) begin errors++; $display("FAIL rand_count: got %0d want 6", obs_q.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (obs_q[i] !== model_blk(4*i, sw)) begin errors++; $display("FAIL rand_data%0d: got %h want %h", i, obs_q[i], model_blk(4*i, sw)); end
      end
    end
    checks++; if (flags.blk_cnt !== 16'd6 || flags.busy !== 1'b1 || flags.done !== 1'b0) begin errors++; $display("FAIL rand_flags: blk_cnt=%0d busy=%b done=%b want 6/1/0", flags.blk_cnt, flags.busy, flags.done); end
  endtask

  initial begin
    test_reset();
    test_single(1'b0, 128'hCCDDEEFF_8899AABB_44556677_00112233);
    test_single(1'b1, 128'hFFEEDDCC_BBAA9988_77665544_33221100);
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_enable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
